// File: rtl/gullfaxi_pkg.sv
// rtl/gullfaxi_pkg.sv - shared widths, state type and port index type for the Gullfaxi output arbiter
package gullfaxi_pkg;

  localparam int GF_NPORTS = 3;
  localparam int LEN_W     = 6;
  localparam int DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } arb_state_e;

  typedef logic [1:0] port_idx_t;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/gullfaxi_rr_picker.sv
// rtl/gullfaxi_rr_picker.sv - combinational round-robin search starting one past the last served port
module gullfaxi_rr_picker
  import gullfaxi_pkg::*;
#(
  parameter int NPORTS = GF_NPORTS
) (
  input  logic [NPORTS-1:0] req,
  input  logic [1:0]        last,
  output logic              valid,
  output logic [1:0]        winner
);

  logic [3:0] req_pad;
  logic [2:0] idx;

  always_comb begin
    req_pad = '0;
    req_pad[NPORTS-1:0] = req;
  end

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      idx = {1'b0, last} + 3'(i);
      if (idx >= 3'(NPORTS)) idx = idx - 3'(NPORTS);
      if (!valid && req_pad[idx[1:0]]) begin
        valid  = 1'b1;
        winner = idx[1:0];
      end
    end
  end

endmodule

// File: rtl/gullfaxi_out_arbiter.sv
// rtl/gullfaxi_out_arbiter.sv - round-robin merge of the output ports onto one registered link
// Optional grant watchdog: GULLFAXI_ARB_WDOG_EN
module gullfaxi_out_arbiter
  import gullfaxi_pkg::*;
#(
  parameter int NPORTS      = GF_NPORTS,
  parameter int WDOG_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        O_req,
  input  logic [NPORTS-1:0]        O_start,
  input  logic [NPORTS*LEN_W-1:0]  O_length,
  input  logic [NPORTS*DATA_W-1:0] O_data,
  input  logic [NPORTS-1:0]        O_end,
  output logic [NPORTS-1:0]        O_grant,
  output logic                     L_start,
  output logic [LEN_W-1:0]         L_length,
  output logic [DATA_W-1:0]        L_data,
  output logic                     L_end,
  output logic [1:0]               L_port,
  output logic                     err
);

  if (NPORTS < 2 || NPORTS > 4 || WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_bad_cfg
    $error("gullfaxi_out_arbiter: unsupported NPORTS or WDOG_CYCLES");
  end

  arb_state_e        state_q, state_d;
  port_idx_t         g_q, g_d;
  port_idx_t         last_q, last_d;
  logic [NPORTS-1:0] grant_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              close;

  logic              l_start_d, l_end_d, err_d, beat;
  logic [LEN_W-1:0]  l_length_d;
  logic [DATA_W-1:0] l_data_d;
  port_idx_t         l_port_d;

  logic              pick_valid;
  port_idx_t         pick_idx;

  logic [3:0]        start_pad, end_pad, req_pad;
  logic [LEN_W-1:0]  len_arr  [4];
  logic [DATA_W-1:0] data_arr [4];
  logic              start_g, end_g, req_g;
  logic [LEN_W-1:0]  len_g;
  logic [DATA_W-1:0] data_g;
  logic [NPORTS-1:0] gmask;

  gullfaxi_rr_picker #(
    .NPORTS (NPORTS)
  ) u_picker (
    .req    (O_req),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Ports are padded to four so the granted index can select without range checks.
  always_comb begin
    start_pad = '0;
    end_pad   = '0;
    req_pad   = '0;
    for (int i = 0; i < 4; i++) begin
      len_arr[i]  = '0;
      data_arr[i] = '0;
    end
    for (int i = 0; i < NPORTS; i++) begin
      start_pad[i] = O_start[i];
      end_pad[i]   = O_end[i];
      req_pad[i]   = O_req[i];
      len_arr[i]   = O_length[i*LEN_W +: LEN_W];
      data_arr[i]  = O_data[i*DATA_W +: DATA_W];
    end
  end

  assign start_g = start_pad[g_q];
  assign end_g   = end_pad[g_q];
  assign req_g   = req_pad[g_q];
  assign len_g   = len_arr[g_q];
  assign data_g  = data_arr[g_q];

  always_comb begin
    gmask = '0;
    for (int i = 0; i < NPORTS; i++) begin
      gmask[i] = (state_q != IDLE) && (g_q == port_idx_t'(i));
    end
  end

`ifdef GULLFAXI_ARB_WDOG_EN
  logic [7:0] wdog_q;
  logic       wdog_hit;

  assign wdog_hit = (wdog_q == 8'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else if (state_q == GRANT) begin
      wdog_q <= wdog_q + 8'd1;
    end else begin
      wdog_q <= '0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    grant_d = O_grant;
    len_d   = len_q;
    cnt_d   = cnt_q;
    close   = 1'b0;
    err_d   = |((O_start | O_end) & ~gmask);

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d           = GRANT;
          g_d               = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (start_g) begin
          len_d = len_g;
          cnt_d = LEN_W'(1);
          if (len_g == '0) err_d = 1'b1;
          if (end_g) begin
            close = 1'b1;
            if (len_g != LEN_W'(1)) err_d = 1'b1;
          end else begin
            state_d = XFER;
          end
        end else if (!req_g) begin
          // Requester withdrew before starting: it keeps its place in the rotation.
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef GULLFAXI_ARB_WDOG_EN
        else if (wdog_hit) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = g_q;
          err_d   = 1'b1;
        end
`endif
      end
      XFER: begin
        cnt_d = sat_inc(cnt_q);
        if (start_g) err_d = 1'b1;
        if (end_g) begin
          close = 1'b1;
          if (cnt_d != len_q) err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (close) begin
      state_d = IDLE;
      grant_d = '0;
      last_d  = g_q;
    end
  end

  always_comb begin
    beat       = ((state_q == GRANT) && start_g) || (state_q == XFER);
    l_start_d  = (state_q == GRANT) && start_g;
    l_length_d = l_start_d ? len_g : '0;
    l_data_d   = beat ? data_g : '0;
    l_end_d    = beat && end_g;
    l_port_d   = beat ? g_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      g_q      <= '0;
      last_q   <= port_idx_t'(NPORTS - 1);
      O_grant  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      L_start  <= 1'b0;
      L_length <= '0;
      L_data   <= '0;
      L_end    <= 1'b0;
      L_port   <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_q   <= last_d;
      O_grant  <= grant_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      L_start  <= l_start_d;
      L_length <= l_length_d;
      L_data   <= l_data_d;
      L_end    <= l_end_d;
      L_port   <= l_port_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_gullfaxi_out_arbiter.sv
// tb/tb_gullfaxi_out_arbiter.sv - scoreboard bench for gullfaxi_out_arbiter
module tb_gullfaxi_out_arbiter;
  import gullfaxi_pkg::*;

  localparam int NP = 3;

  logic                  clk   = 1'b0;
  logic                  reset = 1'b1;
  logic [NP-1:0]         o_req = '0, o_start = '0, o_end = '0;
  logic [NP*LEN_W-1:0]   o_length = '0;
  logic [NP*DATA_W-1:0]  o_data = '0;
  logic [NP-1:0]         o_grant;
  logic                  l_start, l_end, err;
  logic [LEN_W-1:0]      l_length;
  logic [DATA_W-1:0]     l_data;
  logic [1:0]            l_port;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [34:0] exp_grant_q [$];   // {cycle, grant}
  logic [49:0] exp_link_q  [$];   // {cycle, start, length, data, end, port}
  int          exp_err_q   [$];   // cycle of each err pulse
  logic [NP-1:0] prev_grant = '0;

  gullfaxi_out_arbiter #(
    .NPORTS      (NP),
    .WDOG_CYCLES (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .O_req    (o_req),
    .O_start  (o_start),
    .O_length (o_length),
    .O_data   (o_data),
    .O_end    (o_end),
    .O_grant  (o_grant),
    .L_start  (l_start),
    .L_length (l_length),
    .L_data   (l_data),
    .L_end    (l_end),
    .L_port   (l_port),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  task automatic exp_grant(input logic [NP-1:0] g, input int at);
    exp_grant_q.push_back({32'(at), g});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_grant <= '0;
    end else begin
      prev_grant <= o_grant;
      if (o_grant != prev_grant) begin
        if (exp_grant_q.size() == 0) unexpected("grant", 64'({32'(cyc), o_grant}));
        else check("grant", 64'({32'(cyc), o_grant}), 64'(exp_grant_q.pop_front()));
      end
      if (l_start || l_end || (l_data != '0)) begin
        if (exp_link_q.size() == 0)
          unexpected("link", 64'({32'(cyc), l_start, l_length, l_data, l_end, l_port}));
        else
          check("link", 64'({32'(cyc), l_start, l_length, l_data, l_end, l_port}),
                64'(exp_link_q.pop_front()));
      end
      if (err) begin
        if (exp_err_q.size() == 0) unexpected("err", 64'(cyc));
        else check("err", 64'(cyc), 64'(exp_err_q.pop_front()));
      end
    end
  end

  task automatic clear_inputs();
    o_start  = '0;
    o_end    = '0;
    o_length = '0;
    o_data   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    o_req = '0;
    clear_inputs();
    #1;
    check("reset_outputs", 64'({o_grant, l_start, l_length, l_data, l_end, l_port, err}), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Called while the grant for port p is already visible.
  task automatic pkt(input int p, input int len, input int nb, input logic [NP-1:0] clr);
    logic [7:0] b;
    for (int i = 0; i < nb; i++) begin
      b = 8'((p + 1) * 16 + i + 1);
      clear_inputs();
      o_start[p] = (i == 0);
      o_end[p]   = (i == nb - 1);
      if (i == 0) o_length[p*LEN_W +: LEN_W] = 6'(len);
      o_data[p*DATA_W +: DATA_W] = b;
      exp_link_q.push_back({32'(cyc + 1), (i == 0), (i == 0) ? 6'(len) : 6'd0, b, (i == nb - 1), 2'(p)});
      if (i == nb - 1) begin
        exp_grant('0, cyc + 1);
        o_req = o_req & ~clr;
        if (nb != len) exp_err_q.push_back(cyc + 1);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    tick();
    do_reset();

    // single requester on port 1, len 4
    o_req = 3'b010; exp_grant(3'b010, cyc + 1); tick();
    pkt(1, 4, 4, 3'b010);
    tick(); tick();

    // all three requesting: order 0,1,2,0 with one idle cycle between grants
    do_reset();
    o_req = 3'b111; exp_grant(3'b001, cyc + 1); tick();
    pkt(0, 2, 2, 3'b000); exp_grant(3'b010, cyc + 1); tick();
    pkt(1, 2, 2, 3'b000); exp_grant(3'b100, cyc + 1); tick();
    pkt(2, 2, 2, 3'b000); exp_grant(3'b001, cyc + 1); tick();
    pkt(0, 2, 2, 3'b111);
    tick(); tick();

    // length mismatch, single-byte packet, zero length, stray end
    o_req = 3'b100; exp_grant(3'b100, cyc + 1); tick();
    pkt(2, 5, 3, 3'b100);
    o_req = 3'b010; exp_grant(3'b010, cyc + 1); tick();
    pkt(1, 1, 1, 3'b010);
    o_req = 3'b001; exp_grant(3'b001, cyc + 1); tick();
    pkt(0, 0, 1, 3'b001);
    o_end = 3'b010; exp_err_q.push_back(cyc + 1); tick();
    o_end = '0;
    tick(); tick();

    // request withdrawn before start keeps the rotation pointer
    do_reset();
    o_req = 3'b001; exp_grant(3'b001, cyc + 1); tick();
    o_req = 3'b000; exp_grant(3'b000, cyc + 1); tick();
    o_req = 3'b011; exp_grant(3'b001, cyc + 1); tick();
    pkt(0, 3, 3, 3'b001); exp_grant(3'b010, cyc + 1); tick();
    pkt(1, 2, 2, 3'b010);
    tick(); tick();

`ifdef GULLFAXI_ARB_WDOG_EN
    do_reset();
    o_req = 3'b011;
    exp_grant(3'b001, cyc + 1);
    exp_grant(3'b000, cyc + 17);
    exp_err_q.push_back(cyc + 17);
    exp_grant(3'b010, cyc + 18);
    repeat (18) tick();
    pkt(1, 2, 2, 3'b011);
    tick(); tick();
`endif

    // reset in the middle of a port-1 packet, then port 0 wins first
    do_reset();
    o_req = 3'b001; exp_grant(3'b001, cyc + 1); tick();
    pkt(0, 2, 2, 3'b001);
    o_req = 3'b010; exp_grant(3'b010, cyc + 1); tick();
    o_start[1] = 1'b1;
    o_length[LEN_W +: LEN_W] = 6'd6;
    o_data[DATA_W +: DATA_W] = 8'h21;
    exp_link_q.push_back({32'(cyc + 1), 1'b1, 6'd6, 8'h21, 1'b0, 2'd1});
    tick();
    clear_inputs();
    o_data[DATA_W +: DATA_W] = 8'h22;
    tick();
    o_data[DATA_W +: DATA_W] = 8'h23;
    do_reset();
    o_req = 3'b011; exp_grant(3'b001, cyc + 1); tick();
    pkt(0, 2, 2, 3'b001); exp_grant(3'b010, cyc + 1); tick();
    pkt(1, 3, 3, 3'b010);
    tick(); tick(); tick();

    check("grant_queue_drained", 64'(exp_grant_q.size()), 64'd0);
    check("link_queue_drained",  64'(exp_link_q.size()),  64'd0);
    check("err_queue_drained",   64'(exp_err_q.size()),   64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
